// File: rtl/error_sched_pkg.sv
// Shared types for the error replay scheduler.
// FSM encoding, state count and a wrap helper.
package error_sched_pkg;

  localparam int N_STATES = 6;
  localparam int ST_W = $clog2(N_STATES);

  typedef enum logic [ST_W-1:0] {
    S_IDLE,
    S_ACK,
    S_HOLD,
    S_REPLAY,
    S_WAIT,
    S_RELEASE
  } state_t;

  function automatic int wrap_inc(
    input int v,
    input int n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/error_replay_sched_rr_arbiter.sv
// Round-robin pick: lowest ring distance from ptr
// among the requesting stages.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] grant
);

  int w_best;
  int w_dist;

  always_comb begin
    valid  = 1'b0;
    grant  = '0;
    w_best = N;
    w_dist = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i >= int'(ptr)) ? i - int'(ptr)
                                : i + N - int'(ptr);
      if (req[i] && w_dist < w_best) begin
        valid  = 1'b1;
        grant  = IW'(i);
        w_best = w_dist;
      end
    end
  end

endmodule

// File: rtl/error_replay_sched.sv
// Timing-error replay scheduler: stalls the pipe,
// acks one stage, pulses replay, waits, releases.
module error_replay_sched
  import error_sched_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STAGES-1:0]         err_req,
  output logic [STAGES-1:0]         err_ack,
  output logic                      stall,
  output logic [$clog2(STAGES)-1:0] grant_id,
  output logic                      replay,
  input  logic                      replay_done,
  output logic [CNT_W-1:0]          err_total,
  output logic                      err_sat
);

  localparam int IW = $clog2(STAGES);
  localparam int HCW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] H_LAST =
    HCW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state, w_state;
  logic [STAGES-1:0] r_ack, w_ack;
  logic              r_stall, w_stall;
  logic [IW-1:0]     r_gid, w_gid;
  logic              r_replay, w_replay;
  logic [CNT_W-1:0]  r_total, w_total;
  logic              r_sat, w_sat;
  logic [IW-1:0]     r_ptr, w_ptr;
  logic [HCW-1:0]    r_hcnt, w_hcnt;
  logic              w_valid;
  logic [IW-1:0]     w_win;

  rr_arbiter #(
    .N  (STAGES),
    .IW (IW)
  ) u_arb (
    .req   (err_req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .grant (w_win)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ack    <= '0;
      r_stall  <= 1'b0;
      r_gid    <= '0;
      r_replay <= 1'b0;
      r_total  <= '0;
      r_sat    <= 1'b0;
      r_ptr    <= '0;
      r_hcnt   <= '0;
    end else begin
      r_state  <= w_state;
      r_ack    <= w_ack;
      r_stall  <= w_stall;
      r_gid    <= w_gid;
      r_replay <= w_replay;
      r_total  <= w_total;
      r_sat    <= w_sat;
      r_ptr    <= w_ptr;
      r_hcnt   <= w_hcnt;
    end
  end

  // Outputs are computed one step ahead so they leave registers.
  always_comb begin
    w_state  = r_state;
    w_ack    = r_ack;
    w_stall  = r_stall;
    w_gid    = r_gid;
    w_replay = 1'b0;
    w_total  = r_total;
    w_sat    = r_sat;
    w_ptr    = r_ptr;
    w_hcnt   = r_hcnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_state = S_ACK;
          w_ack   = STAGES'(1) << w_win;
          w_stall = 1'b1;
          w_gid   = w_win;
          if (r_total == CNT_MAX) w_sat = 1'b1;
          else w_total = r_total + 1'b1;
        end
      end
      S_ACK: begin
        if (HOLD_CYCLES == 0) begin
          w_state  = S_REPLAY;
          w_replay = 1'b1;
        end else begin
          w_state = S_HOLD;
          w_hcnt  = '0;
        end
      end
      S_HOLD: begin
        if (r_hcnt == H_LAST) begin
          w_state  = S_REPLAY;
          w_replay = 1'b1;
        end else begin
          w_hcnt = r_hcnt + 1'b1;
        end
      end
      S_REPLAY: w_state = S_WAIT;
      S_WAIT: begin
        if (replay_done) w_state = S_RELEASE;
      end
      S_RELEASE: begin
        if (!err_req[r_gid]) begin
          w_state = S_IDLE;
          w_ack   = '0;
          w_stall = 1'b0;
          w_ptr   = IW'(wrap_inc(int'(r_gid), STAGES));
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign err_ack   = r_ack;
  assign stall     = r_stall;
  assign grant_id  = r_gid;
  assign replay    = r_replay;
  assign err_total = r_total;
  assign err_sat   = r_sat;

endmodule

// File: tb/tb_error_replay_sched.sv
// Directed bench: instance A default params,
// instance B with CNT_W=2 and HOLD_CYCLES=0.
module tb_error_replay_sched;

  logic       clk;
  logic       rst;
  logic [2:0] a_req, a_ack, b_req, b_ack;
  logic       a_stall, a_replay, a_done, a_sat;
  logic       b_stall, b_replay, b_done, b_sat;
  logic [1:0] a_gid, b_gid;
  logic [7:0] a_total;
  logic [1:0] b_total;
  int         n_run;
  int         n_fail;

  error_replay_sched #(
    .STAGES(3), .CNT_W(8), .HOLD_CYCLES(2)
  ) u_a (
    .clk(clk), .rst(rst),
    .err_req(a_req), .err_ack(a_ack),
    .stall(a_stall), .grant_id(a_gid),
    .replay(a_replay), .replay_done(a_done),
    .err_total(a_total), .err_sat(a_sat)
  );

  error_replay_sched #(
    .STAGES(3), .CNT_W(2), .HOLD_CYCLES(0)
  ) u_b (
    .clk(clk), .rst(rst),
    .err_req(b_req), .err_ack(b_ack),
    .stall(b_stall), .grant_id(b_gid),
    .replay(b_replay), .replay_done(b_done),
    .err_total(b_total), .err_sat(b_sat)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_a(
    input logic [1:0] gid,
    input int         tot
  );
    tick;
    chk("a_ack", 32'(a_ack), 32'(1) << gid);
    chk("a_gid", 32'(a_gid), 32'(gid));
    chk("a_stall", 32'(a_stall), 1);
    chk("a_total", 32'(a_total), tot);
    tick;
    tick;
    chk("a_hold_rp", 32'(a_replay), 0);
    tick;
    chk("a_replay", 32'(a_replay), 1);
    tick;
    chk("a_wait_rp", 32'(a_replay), 0);
    tick;
    chk("a_rel_ack", 32'(a_ack), 32'(1) << gid);
    a_req[gid] = 1'b0;
    tick;
    chk("a_idle_st", 32'(a_stall), 0);
    chk("a_idle_ack", 32'(a_ack), 0);
  endtask

  task automatic run_b(
    input int tot,
    input int sat
  );
    b_req = 3'b001;
    tick;
    chk("b_ack", 32'(b_ack), 1);
    chk("b_total", 32'(b_total), tot);
    chk("b_sat", 32'(b_sat), sat);
    tick;
    chk("b_replay", 32'(b_replay), 1);
    tick;
    tick;
    chk("b_rel_ack", 32'(b_ack), 1);
    b_req = 3'b000;
    tick;
    chk("b_idle_st", 32'(b_stall), 0);
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b0;
    a_req  = '0;
    b_req  = '0;
    a_done = 1'b0;
    b_done = 1'b0;
    n_run  = 0;
    n_fail = 0;
    tick;
    tick;
    chk("rst_ack", 32'(a_ack), 0);
    chk("rst_stall", 32'(a_stall), 0);
    chk("rst_gid", 32'(a_gid), 0);
    chk("rst_replay", 32'(a_replay), 0);
    chk("rst_total", 32'(a_total), 0);
    chk("rst_sat", 32'(a_sat), 0);
    chk("rst_b_ack", 32'(b_ack), 0);
    chk("rst_b_total", 32'(b_total), 0);
    rst = 1'b1;

    // simultaneous requests, order 0,1,2
    a_req  = 3'b111;
    a_done = 1'b1;
    run_a(2'd0, 1);
    run_a(2'd1, 2);
    run_a(2'd2, 3);

    // single request, replay_done late
    a_done = 1'b0;
    a_req  = 3'b010;
    tick;
    chk("s_ack", 32'(a_ack), 32'b010);
    chk("s_gid", 32'(a_gid), 1);
    chk("s_stall", 32'(a_stall), 1);
    chk("s_total", 32'(a_total), 4);
    chk("s_rp_c1", 32'(a_replay), 0);
    tick;
    chk("s_rp_c2", 32'(a_replay), 0);
    tick;
    chk("s_rp_c3", 32'(a_replay), 0);
    tick;
    chk("s_rp_c4", 32'(a_replay), 1);
    tick;
    chk("s_rp_c5", 32'(a_replay), 0);
    tick;
    chk("s_wait_ack", 32'(a_ack), 32'b010);
    chk("s_wait_st", 32'(a_stall), 1);
    a_done = 1'b1;
    tick;
    chk("s_rel_ack", 32'(a_ack), 32'b010);
    tick;
    chk("s_hold_ack", 32'(a_ack), 32'b010);
    chk("s_hold_st", 32'(a_stall), 1);
    a_req = 3'b000;
    tick;
    chk("s_drop_ack", 32'(a_ack), 0);
    chk("s_drop_st", 32'(a_stall), 0);

    // wrap from ptr=2 to stage 0, stage 2 pending
    a_req = 3'b001;
    tick;
    chk("w_gid0", 32'(a_gid), 0);
    chk("w_ack0", 32'(a_ack), 32'b001);
    chk("w_total", 32'(a_total), 5);
    a_req = 3'b101;
    tick;
    chk("w_keep_gid", 32'(a_gid), 0);
    chk("w_keep_ack", 32'(a_ack), 32'b001);
    tick;
    tick;
    chk("w_replay", 32'(a_replay), 1);
    tick;
    tick;
    a_req = 3'b100;
    tick;
    chk("w_idle_ack", 32'(a_ack), 0);
    run_a(2'd2, 6);

    // HOLD_CYCLES=0 instance
    b_req  = 3'b001;
    b_done = 1'b1;
    tick;
    chk("h0_ack", 32'(b_ack), 1);
    chk("h0_rp_c1", 32'(b_replay), 0);
    chk("h0_total", 32'(b_total), 1);
    tick;
    chk("h0_rp_c2", 32'(b_replay), 1);
    tick;
    chk("h0_rp_c3", 32'(b_replay), 0);
    chk("h0_wait_ack", 32'(b_ack), 1);
    tick;
    tick;
    chk("h0_held_ack", 32'(b_ack), 1);
    chk("h0_held_st", 32'(b_stall), 1);
    b_req = 3'b000;
    tick;
    chk("h0_drop_ack", 32'(b_ack), 0);

    // saturation with CNT_W=2
    run_b(2, 0);
    run_b(3, 0);
    run_b(3, 1);
    run_b(3, 1);

    // reset in WAIT, re-arbitrate from ptr=0
    a_req = 3'b010;
    run_a(2'd1, 7);
    a_done = 1'b0;
    a_req  = 3'b110;
    tick;
    chk("r_gid2", 32'(a_gid), 2);
    chk("r_total", 32'(a_total), 8);
    tick;
    tick;
    tick;
    tick;
    chk("r_wait_st", 32'(a_stall), 1);
    rst = 1'b0;
    tick;
    chk("r_ack", 32'(a_ack), 0);
    chk("r_stall", 32'(a_stall), 0);
    chk("r_gid", 32'(a_gid), 0);
    chk("r_replay", 32'(a_replay), 0);
    chk("r_tot0", 32'(a_total), 0);
    chk("r_b_sat", 32'(b_sat), 0);
    chk("r_b_tot", 32'(b_total), 0);
    rst = 1'b1;
    tick;
    chk("r_re_gid", 32'(a_gid), 1);
    chk("r_re_ack", 32'(a_ack), 32'b010);
    chk("r_re_tot", 32'(a_total), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
